// File: rtl/poly_note_allocator_if.sv
// Report handshake bundle for poly_note_allocator.
//   report_valid : producer has a HID report on keycodes
//   report_ready : allocator is idle and will accept a report
//   keycodes     : NUM_KEYS keycode slots, slot k = bits [8k+7:8k], 0x00 = empty
interface poly_note_allocator_if #(
  parameter int unsigned NUM_KEYS = 6
) ();
  logic                  report_valid;
  logic                  report_ready;
  logic [8*NUM_KEYS-1:0] keycodes;

  modport master (output report_valid, output keycodes, input report_ready);
  modport slave  (input report_valid, input keycodes, output report_ready);
endinterface

// File: rtl/poly_note_allocator.sv
// Polyphonic note allocator: diffs each HID keyboard report against the
// previous one, releases voices for lifted keys and allocates voices for new
// keys (lowest free voice, otherwise steal the oldest).
//   Clk, Reset_n  : clock, asynchronous active-low reset
//   rpt           : report handshake (valid/ready/keycodes)
//   octaveBase    : one-hot octave select, sampled at each press
//   panic         : synchronous release of all voices, abandons any scan
//   voice_noteIdx : 7-bit note index per voice
//   voice_gate    : voice held
//   voice_trig    : 1-cycle pulse on (re)allocation
//   voice_off     : 1-cycle pulse on release
//   busy          : ~report_ready
module poly_note_allocator #(
  parameter int unsigned NUM_KEYS   = 6,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_W      = 8
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  poly_note_allocator_if.slave    rpt,
  input  logic [7:0]              octaveBase,
  input  logic                    panic,
  output logic [7*NUM_VOICES-1:0] voice_noteIdx,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [NUM_VOICES-1:0]   voice_off,
  output logic                    busy
);
  localparam int unsigned KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [KW-1:0] LAST_SLOT = KW'(NUM_KEYS - 1);

  typedef enum logic [1:0] {IDLE, REL, PRS, COMMIT} state_t;

  state_t        state, state_n;
  logic [KW-1:0] slot, slot_n;

  logic [7:0]       cur  [NUM_KEYS];
  logic [7:0]       prev [NUM_KEYS];
  logic [7:0]       vkey [NUM_VOICES];
  logic [AGE_W-1:0] age  [NUM_VOICES];
  logic [6:0]       note [NUM_VOICES];

  logic                  ready, accept, rollover;
  logic [7:0]            cur_k, prev_k;
  logic [5:0]            cur_map, prev_map;
  logic                  prev_in_cur, cur_in_prev, held, any_free;
  logic [NUM_VOICES-1:0] rel_mask;
  logic [VW-1:0]         tgt, victim;
  logic [AGE_W-1:0]      best_age;
  logic                  do_rel, do_prs;
  logic [6:0]            new_note;

  // {mapped, noteNum[4:0]}
  function automatic logic [5:0] note_map(input logic [7:0] kc);
    case (kc)
      8'h1D: return {1'b1, 5'd0};
      8'h04: return {1'b1, 5'd1};
      8'h1B: return {1'b1, 5'd2};
      8'h16: return {1'b1, 5'd3};
      8'h06: return {1'b1, 5'd4};
      8'h07: return {1'b1, 5'd5};
      8'h19: return {1'b1, 5'd6};
      8'h09: return {1'b1, 5'd7};
      8'h05: return {1'b1, 5'd8};
      8'h0A: return {1'b1, 5'd9};
      8'h11: return {1'b1, 5'd10};
      8'h0B: return {1'b1, 5'd11};
      8'h10: return {1'b1, 5'd12};
      8'h0D: return {1'b1, 5'd13};
      8'h36: return {1'b1, 5'd14};
      8'h0E: return {1'b1, 5'd15};
      8'h37: return {1'b1, 5'd16};
      8'h0F: return {1'b1, 5'd17};
      8'h38: return {1'b1, 5'd18};
      8'h33: return {1'b1, 5'd19};
      8'h34: return {1'b1, 5'd21};
      8'h14: return {1'b1, 5'd10};
      8'h1A: return {1'b1, 5'd12};
      8'h08: return {1'b1, 5'd14};
      8'h15: return {1'b1, 5'd16};
      8'h17: return {1'b1, 5'd18};
      8'h1C: return {1'b1, 5'd20};
      8'h18: return {1'b1, 5'd22};
      8'h0C: return {1'b1, 5'd24};
      8'h12: return {1'b1, 5'd26};
      8'h13: return {1'b1, 5'd28};
      default: return '0;
    endcase
  endfunction

  function automatic logic [6:0] note_base(input logic [7:0] oct);
    case (oct)
      8'h80:   return 7'd6;
      8'h40:   return 7'd18;
      8'h20:   return 7'd30;
      8'h10:   return 7'd42;
      8'h08:   return 7'd54;
      8'h04:   return 7'd66;
      8'h02:   return 7'd78;
      default: return 7'd90;
    endcase
  endfunction

  assign ready            = (state == IDLE);
  assign rpt.report_ready = ready;
  assign busy             = ~ready;

  always_comb begin
    voice_noteIdx = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) voice_noteIdx[7*v +: 7] = note[v];
  end

  // Per-slot decode for the REL/PRS step currently being processed.
  always_comb begin
    rollover = 1'b0;
    for (int unsigned k = 0; k < NUM_KEYS; k++)
      if (rpt.keycodes[8*k +: 8] == 8'h01) rollover = 1'b1;

    cur_k    = cur[slot];
    prev_k   = prev[slot];
    cur_map  = note_map(cur_k);
    prev_map = note_map(prev_k);

    prev_in_cur = 1'b0;
    cur_in_prev = 1'b0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (cur[k] == prev_k) prev_in_cur = 1'b1;
      if (prev[k] == cur_k) cur_in_prev = 1'b1;
    end

    held     = 1'b0;
    rel_mask = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (voice_gate[v] && vkey[v] == cur_k)  held        = 1'b1;
      if (voice_gate[v] && vkey[v] == prev_k) rel_mask[v] = 1'b1;
    end

    any_free = 1'b0;
    tgt      = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++)
      if (!voice_gate[v] && !any_free) begin
        any_free = 1'b1;
        tgt      = VW'(v);
      end

    // Strict '>' keeps the lowest index on equal ages.
    victim   = '0;
    best_age = age[0];
    for (int unsigned v = 1; v < NUM_VOICES; v++)
      if (age[v] > best_age) begin
        best_age = age[v];
        victim   = VW'(v);
      end
    if (!any_free) tgt = victim;

    new_note = note_base(octaveBase) + {2'b00, cur_map[4:0]};
    do_rel   = (state == REL) && prev_map[5] && !prev_in_cur;
    do_prs   = (state == PRS) && cur_map[5] && !cur_in_prev && !held;
  end

  always_comb begin
    state_n = state;
    slot_n  = slot;
    accept  = 1'b0;
    case (state)
      IDLE:
        if (rpt.report_valid && !rollover) begin
          accept  = 1'b1;
          state_n = REL;
          slot_n  = '0;
        end
      REL:
        if (slot == LAST_SLOT) begin
          state_n = PRS;
          slot_n  = '0;
        end else begin
          slot_n = slot + KW'(1);
        end
      PRS:
        if (slot == LAST_SLOT) begin
          state_n = COMMIT;
          slot_n  = '0;
        end else begin
          slot_n = slot + KW'(1);
        end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (panic) begin
      state_n = IDLE;
      slot_n  = '0;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      slot  <= '0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      voice_gate <= '0;
      voice_trig <= '0;
      voice_off  <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        vkey[v] <= '0;
        age[v]  <= '0;
        note[v] <= '0;
      end
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        cur[k]  <= '0;
        prev[k] <= '0;
      end
    end else begin
      voice_trig <= '0;
      voice_off  <= '0;
      if (panic) begin
        voice_off  <= voice_gate;
        voice_gate <= '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) prev[k] <= '0;
      end else begin
        if (accept)
          for (int unsigned k = 0; k < NUM_KEYS; k++) cur[k] <= rpt.keycodes[8*k +: 8];
        if (do_rel) begin
          voice_gate <= voice_gate & ~rel_mask;
          voice_off  <= rel_mask;
        end
        if (do_prs) begin
          for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (VW'(v) == tgt) begin
              vkey[v]       <= cur_k;
              note[v]       <= new_note;
              age[v]        <= '0;
              voice_gate[v] <= 1'b1;
              voice_trig[v] <= 1'b1;
            end else if (voice_gate[v] && age[v] != '1) begin
              age[v] <= age[v] + AGE_W'(1);
            end
          end
        end
        if (state == COMMIT)
          for (int unsigned k = 0; k < NUM_KEYS; k++) prev[k] <= cur[k];
      end
    end
  end
endmodule

// File: tb/tb_poly_note_allocator.sv
module tb_poly_note_allocator;
  localparam int NK = 6;
  localparam int NV = 4;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic [7:0]      octaveBase;
  logic            panic;
  logic [7*NV-1:0] voice_noteIdx;
  logic [NV-1:0]   voice_gate, voice_trig, voice_off;
  logic            busy;

  poly_note_allocator_if #(.NUM_KEYS(NK)) rif ();

  poly_note_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .AGE_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .rpt(rif), .octaveBase(octaveBase), .panic(panic),
    .voice_noteIdx(voice_noteIdx), .voice_gate(voice_gate), .voice_trig(voice_trig),
    .voice_off(voice_off), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int trig_cnt [NV];
  int off_cnt  [NV];

  localparam logic [7:0] MAP_KC [31] = '{
    8'h1D, 8'h04, 8'h1B, 8'h16, 8'h06, 8'h07, 8'h19, 8'h09, 8'h05, 8'h0A, 8'h11,
    8'h0B, 8'h10, 8'h0D, 8'h36, 8'h0E, 8'h37, 8'h0F, 8'h38, 8'h33, 8'h34,
    8'h14, 8'h1A, 8'h08, 8'h15, 8'h17, 8'h1C, 8'h18, 8'h0C, 8'h12, 8'h13};
  localparam int MAP_NN [31] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 21,
    10, 12, 14, 16, 18, 20, 22, 24, 26, 28};
  localparam logic [7:0] OCTS [11] = '{
    8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00, 8'hFF, 8'h03};

  // Reference model: voices as plain arrays, report processed as a whole.
  logic [7:0] m_prev [NK];
  logic [7:0] m_key  [NV];
  bit         m_gate [NV];
  int         m_age  [NV];
  int         m_note [NV];
  int         m_trig [NV];
  int         m_off  [NV];

  typedef struct {
    logic [47:0] kc;
    logic [7:0]  oct;
    bit          acc;
    logic [3:0]  gate;
    logic [3:0]  trig;
    logic [3:0]  off;
    logic [27:0] notes;
  } vec_t;
  vec_t vecs [12];

  logic [47:0] rkc;
  int          lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset_n) begin
      for (int v = 0; v < NV; v++) begin
        if (voice_trig[v]) trig_cnt[v]++;
        if (voice_off[v])  off_cnt[v]++;
      end
      checks++;
      if ((voice_trig & voice_off) != '0) begin
        failures++;
        $display("FAIL trig_off_overlap actual=%b/%b required=disjoint", voice_trig, voice_off);
      end
      checks++;
      if (busy !== ~rif.report_ready) begin
        failures++;
        $display("FAIL busy_vs_ready actual=%b required=%b", busy, ~rif.report_ready);
      end
    end
  end

  function automatic bit lookup(input logic [7:0] kc, output int nn);
    nn = 0;
    for (int i = 0; i < 31; i++)
      if (MAP_KC[i] == kc) begin
        nn = MAP_NN[i];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic int base_of(input logic [7:0] oct);
    for (int i = 0; i < 8; i++)
      if (oct == (8'h80 >> i)) return 6 + 12 * i;
    return 90;
  endfunction

  function automatic bit in_list(input logic [7:0] lst [NK], input logic [7:0] kc);
    for (int i = 0; i < NK; i++) if (lst[i] == kc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NK; k++) m_prev[k] = '0;
    for (int v = 0; v < NV; v++) begin
      m_key[v] = '0; m_gate[v] = 1'b0; m_age[v] = 0; m_note[v] = 0;
      m_trig[v] = 0; m_off[v] = 0;
    end
  endtask

  task automatic clear_pulses();
    for (int v = 0; v < NV; v++) begin
      trig_cnt[v] = 0; off_cnt[v] = 0; m_trig[v] = 0; m_off[v] = 0;
    end
  endtask

  task automatic model_panic();
    for (int v = 0; v < NV; v++)
      if (m_gate[v]) begin
        m_gate[v] = 1'b0;
        m_off[v]++;
      end
    for (int k = 0; k < NK; k++) m_prev[k] = '0;
  endtask

  task automatic model_apply(input logic [47:0] kc, input logic [7:0] oct, output bit acc);
    logic [7:0] nw [NK];
    int nn, t;
    bit held;
    for (int k = 0; k < NK; k++) nw[k] = kc[8*k +: 8];
    acc = 1'b0;
    for (int k = 0; k < NK; k++) if (nw[k] == 8'h01) return;
    acc = 1'b1;
    for (int k = 0; k < NK; k++)
      if (lookup(m_prev[k], nn) && !in_list(nw, m_prev[k]))
        for (int v = 0; v < NV; v++)
          if (m_gate[v] && m_key[v] == m_prev[k]) begin
            m_gate[v] = 1'b0;
            m_off[v]++;
          end
    for (int k = 0; k < NK; k++)
      if (lookup(nw[k], nn) && !in_list(m_prev, nw[k])) begin
        held = 1'b0;
        for (int v = 0; v < NV; v++) if (m_gate[v] && m_key[v] == nw[k]) held = 1'b1;
        if (!held) begin
          t = -1;
          for (int v = 0; v < NV; v++) if (!m_gate[v] && t < 0) t = v;
          if (t < 0) begin
            t = 0;
            for (int v = 1; v < NV; v++) if (m_age[v] > m_age[t]) t = v;
          end
          for (int v = 0; v < NV; v++)
            if (v != t && m_gate[v] && m_age[v] < 255) m_age[v]++;
          m_gate[t] = 1'b1; m_key[t] = nw[k]; m_age[t] = 0;
          m_note[t] = base_of(oct) + nn;
          m_trig[t]++;
        end
      end
    for (int k = 0; k < NK; k++) m_prev[k] = nw[k];
  endtask

  task automatic compare_model();
    for (int v = 0; v < NV; v++) begin
      chk($sformatf("gate_v%0d", v), voice_gate[v], m_gate[v]);
      chk($sformatf("note_v%0d", v), voice_noteIdx[7*v +: 7], m_note[v]);
      chk($sformatf("trig_count_v%0d", v), trig_cnt[v], m_trig[v]);
      chk($sformatf("off_count_v%0d", v), off_cnt[v], m_off[v]);
    end
  endtask

  task automatic send(input logic [47:0] kc, input logic [7:0] oct, output int l);
    bit acc;
    l = 0;
    while (!rif.report_ready && l < 100) begin @(negedge Clk); #1; l++; end
    chk("ready_before_send", rif.report_ready, 1);
    clear_pulses();
    rif.keycodes = kc; octaveBase = oct; rif.report_valid = 1'b1;
    model_apply(kc, oct, acc);
    @(negedge Clk); #1;
    rif.report_valid = 1'b0;
    l = 0;
    while (!rif.report_ready && l < 60) begin @(negedge Clk); #1; l++; end
    chk("accept_to_ready_latency", l, acc ? 13 : 0);
    compare_model();
  endtask

  task automatic panic_idle();
    clear_pulses();
    panic = 1'b1;
    @(negedge Clk); #1;
    panic = 1'b0;
    model_panic();
    compare_model();
  endtask

  task automatic gen_report(input logic [47:0] old, output logic [47:0] kc);
    int r;
    logic [7:0] b;
    kc = old;
    for (int k = 0; k < NK; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       b = old[8*k +: 8];
      else if (r < 6)  b = 8'h00;
      else if (r < 8)  b = MAP_KC[$urandom_range(0, 13)];
      else if (r == 8) b = 8'h2C;
      else             b = kc[7:0];
      kc[8*k +: 8] = b;
    end
    if ($urandom_range(0, 14) == 0) kc[8*$urandom_range(0, NK-1) +: 8] = 8'h01;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{48'h00_00_00_00_00_1D, 8'h08, 1'b1, 4'b0001, 4'b0001, 4'b0000, {7'd0,  7'd0,   7'd0,  7'd54}};
    vecs[1]  = '{48'h00_00_00_00_04_1D, 8'h08, 1'b1, 4'b0011, 4'b0010, 4'b0000, {7'd0,  7'd0,   7'd55, 7'd54}};
    vecs[2]  = '{48'h00_00_00_00_00_00, 8'h08, 1'b1, 4'b0000, 4'b0000, 4'b0011, {7'd0,  7'd0,   7'd55, 7'd54}};
    vecs[3]  = '{48'h00_00_00_00_00_1D, 8'h08, 1'b1, 4'b0001, 4'b0001, 4'b0000, {7'd0,  7'd0,   7'd55, 7'd54}};
    vecs[4]  = '{48'h00_00_00_00_04_1D, 8'h08, 1'b1, 4'b0011, 4'b0010, 4'b0000, {7'd0,  7'd0,   7'd55, 7'd54}};
    vecs[5]  = '{48'h00_00_00_1B_04_1D, 8'h08, 1'b1, 4'b0111, 4'b0100, 4'b0000, {7'd0,  7'd56,  7'd55, 7'd54}};
    vecs[6]  = '{48'h00_00_16_1B_04_1D, 8'h08, 1'b1, 4'b1111, 4'b1000, 4'b0000, {7'd57, 7'd56,  7'd55, 7'd54}};
    vecs[7]  = '{48'h00_05_06_16_1B_04, 8'h08, 1'b1, 4'b1111, 4'b0011, 4'b0001, {7'd57, 7'd56,  7'd62, 7'd58}};
    vecs[8]  = '{48'h01_05_06_16_1B_04, 8'h08, 1'b0, 4'b1111, 4'b0000, 4'b0000, {7'd57, 7'd56,  7'd62, 7'd58}};
    vecs[9]  = '{48'h13_05_06_16_1B_04, 8'h01, 1'b1, 4'b1111, 4'b0100, 4'b0000, {7'd57, 7'd118, 7'd62, 7'd58}};
    vecs[10] = '{48'h00_00_00_00_00_00, 8'h08, 1'b1, 4'b0000, 4'b0000, 4'b1111, {7'd57, 7'd118, 7'd62, 7'd58}};
    vecs[11] = '{48'h00_00_00_1B_04_1D, 8'h08, 1'b1, 4'b0111, 4'b0111, 4'b0000, {7'd57, 7'd56,  7'd55, 7'd54}};

    Reset_n = 1'b0; panic = 1'b0; octaveBase = 8'h00;
    rif.report_valid = 1'b0; rif.keycodes = '0;
    model_reset();
    clear_pulses();
    #12;
    chk("reset_noteIdx", voice_noteIdx, 0);
    chk("reset_gate", voice_gate, 0);
    chk("reset_trig", voice_trig, 0);
    chk("reset_off", voice_off, 0);
    chk("reset_ready", rif.report_ready, 1);
    chk("reset_busy", busy, 0);
    @(negedge Clk); #1;
    Reset_n = 1'b1;
    @(negedge Clk); #1;

    for (int i = 0; i < 12; i++) begin
      logic [3:0] tm, om;
      send(vecs[i].kc, vecs[i].oct, lat);
      for (int v = 0; v < NV; v++) begin
        tm[v] = (trig_cnt[v] != 0);
        om[v] = (off_cnt[v] != 0);
      end
      chk($sformatf("tbl%0d_latency", i), lat, vecs[i].acc ? 13 : 0);
      chk($sformatf("tbl%0d_gate", i), voice_gate, vecs[i].gate);
      chk($sformatf("tbl%0d_trig_mask", i), tm, vecs[i].trig);
      chk($sformatf("tbl%0d_off_mask", i), om, vecs[i].off);
      chk($sformatf("tbl%0d_notes", i), voice_noteIdx, vecs[i].notes);
    end

    // Panic while the PRS scan is at slot 2, with three voices gated.
    clear_pulses();
    rif.keycodes = 48'h00_06_16_1B_04_1D; octaveBase = 8'h08; rif.report_valid = 1'b1;
    @(negedge Clk); #1;
    rif.report_valid = 1'b0;
    repeat (8) @(negedge Clk);
    #1;
    chk("panic_pre_busy", busy, 1);
    chk("panic_pre_gate", voice_gate, 4'b0111);
    panic = 1'b1;
    @(negedge Clk); #1;
    panic = 1'b0;
    chk("panic_off_same_cycle", voice_off, 4'b0111);
    chk("panic_gate_cleared", voice_gate, 4'b0000);
    chk("panic_ready_next_cycle", rif.report_ready, 1);
    model_panic();
    compare_model();

    send(48'h00_06_16_1B_04_1D, 8'h08, lat);
    chk("repress_v0_retrig_count", trig_cnt[0], 2);
    chk("repress_v0_note", voice_noteIdx[6:0], 58);
    chk("repress_gate", voice_gate, 4'b1111);

    rkc = 48'h00_06_16_1B_04_1D;
    for (int it = 0; it < 60; it++) begin
      gen_report(rkc, rkc);
      send(rkc, OCTS[$urandom_range(0, 10)], lat);
      if ($urandom_range(0, 9) == 0) panic_idle();
    end

    // Asynchronous reset in the middle of a scan.
    send(48'h00_00_00_1B_04_1D, 8'h40, lat);
    rif.keycodes = 48'h00_00_16_1B_04_1D; octaveBase = 8'h08; rif.report_valid = 1'b1;
    @(negedge Clk); #1;
    rif.report_valid = 1'b0;
    repeat (9) @(negedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("midscan_reset_gate", voice_gate, 0);
    chk("midscan_reset_notes", voice_noteIdx, 0);
    chk("midscan_reset_trig", voice_trig, 0);
    chk("midscan_reset_off", voice_off, 0);
    chk("midscan_reset_ready", rif.report_ready, 1);
    @(negedge Clk); #1;
    Reset_n = 1'b1;
    model_reset();
    @(negedge Clk); #1;
    send(48'h00_00_00_00_00_1D, 8'h80, lat);
    chk("post_reset_v0_note", voice_noteIdx[6:0], 6);
    chk("post_reset_v0_trig", trig_cnt[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/poly_note_allocator.md
Name: poly_note_allocator

Overview:
Polyphonic successor to the single-note keycode parser. Takes full USB HID keyboard reports (NUM_KEYS keycode slots) and diffs each report against the previous one. Presses and releases are mapped onto NUM_VOICES synth voices, with oldest-voice stealing. Per-voice note index, gate, trigger pulse and off pulse feed the oscillator/envelope bank.

Parameters:
NUM_KEYS, 6, keycode slots per HID report
NUM_VOICES, 4, voices managed (1..16)
AGE_W, 8, width of per-voice age counter (saturating)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
report_valid  in  1  new report present on keycodes
report_ready  out  1  high in IDLE; report accepted when valid&ready
keycodes  in  8*NUM_KEYS  slot k = bits [8k+7:8k]; 0x00 = empty slot
octaveBase  in  8  one-hot octave select, sampled at each press
panic  in  1  release all voices
voice_noteIdx  out  7*NUM_VOICES  note index per voice
voice_gate  out  NUM_VOICES  voice held
voice_trig  out  NUM_VOICES  1-cycle pulse on (re)allocation
voice_off  out  NUM_VOICES  1-cycle pulse on release
busy  out  1  equals ~report_ready

Behaviour:
- Reset (async, Reset_n=0): state IDLE. All voice_* outputs 0. Stored voice keycodes 0, ages 0, previous-report register all 0x00.
- Note map (noteNum):
  - Lower rows: 1D→0, 04→1, 1B→2, 16→3, 06→4, 07→5, 19→6, 09→7, 05→8, 0A→9, 11→10, 0B→11, 10→12, 0D→13, 36→14, 0E→15, 37→16, 0F→17, 38→18, 33→19, 34→21.
  - Upper row: 14→10, 1A→12, 08→14, 15→16, 17→18, 1C→20, 18→22, 0C→24, 12→26, 13→28.
  - All other keycodes are unmapped and ignored.
- noteBase from octaveBase: 80→6, 40→18, 20→30, 10→42, 08→54, 04→66, 02→78, 01→90, any other value→90. noteIdx = noteBase + noteNum, 7-bit unsigned; max 118, so no overflow.
- FSM: IDLE → REL(k=0..NUM_KEYS-1) → PRS(k=0..NUM_KEYS-1) → COMMIT → IDLE.
  - Capture happens on valid&ready in IDLE.
  - Accept-to-ready latency is exactly 2*NUM_KEYS+1 cycles.
- Rollover report: any slot = 0x01 → report discarded in IDLE. No state change, previous report kept, report_ready stays 1.
- REL(k), one slot per cycle:
  - Condition: prev[k] is mapped and absent from the new report.
  - The voice with gate=1 and stored keycode = prev[k] goes gate←0, voice_off pulses that cycle.
  - No matching voice (already stolen) → no action.
- PRS(k), one slot per cycle:
  - Condition: new[k] is mapped, absent from prev, and not already held by any gated voice.
  - Allocation target: lowest-index voice with gate=0. If none free, steal the voice with the largest age (ties → lowest index).
  - Target loads noteIdx (octave sampled this cycle), stores the keycode, gate←1, age←0, voice_trig pulses.
  - On a steal, voice_off is NOT pulsed for the victim.
  - Same cycle: every other gated voice's age increments, saturating at 2^AGE_W-1.
- Duplicate keycode in one report: only the first slot allocates. Later duplicates hit the "already held" rule and do nothing.
- COMMIT: prev ← captured report.
- Octave change while notes are held: held voices keep their noteIdx. Release still matches by keycode.
- panic (synchronous, highest priority, any state):
  - Every gated voice: gate←0, voice_off pulses.
  - prev ← all 0x00, FSM → IDLE. Any in-flight report is abandoned.
- Reset_n asserted mid-scan: immediate return to reset values. No pulses are emitted.
- voice_trig and voice_off are never high for the same voice in the same cycle.

Test Plan:
- Reset, then octaveBase=0x08, report {1D,0,0,0,0,0} → after 13 cycles: voice0 noteIdx=54, gate=1, exactly one trig pulse on voice0. Others idle.
- Continuing, report {1D,04,0,0,0,0} → voice1 noteIdx=55, trig on voice1 only. Voice0 unchanged, no re-trig.
- Report all zeros → off pulses on voice0 and voice1 in REL cycles k=0 and k=1. Both gates 0.
- NUM_VOICES=4, press 1D,04,1B,16 in four successive reports, then report {04,1B,16,06,05,0} (1D released, 06 and 05 new) → 06 takes freed voice0 (noteIdx base+4). 05 steals the oldest remaining voice (voice1, key 04) with trig but no off pulse. noteIdx = base+8.
- Report containing 0x01 → report_ready stays high, all outputs unchanged. Same report with 0x13 at octaveBase=0x01 → noteIdx=118.
- Assert panic during PRS k=2 with 3 voices gated → all three off pulse the same cycle, FSM in IDLE next cycle. Following identical report re-triggers all keys.
